// File: rtl/reg_write_arbiter_if.sv
// Write-request handshake and register-file write bus shared by the arbiter
// and its two writeback requesters (A = ALU, B = load).
interface reg_write_arbiter_if;
    logic        ReqA_Valid;
    logic [4:0]  ReqA_Reg;
    logic [31:0] ReqA_Data;
    logic        ReqA_Ready;
    logic        ReqB_Valid;
    logic [4:0]  ReqB_Reg;
    logic [31:0] ReqB_Data;
    logic        ReqB_Ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        InitDone;

    modport slave (
        input  ReqA_Valid, ReqA_Reg, ReqA_Data,
        input  ReqB_Valid, ReqB_Reg, ReqB_Data,
        output ReqA_Ready, ReqB_Ready,
        output RegWrite, WriteRegister, WriteData, InitDone
    );

    modport master (
        output ReqA_Valid, ReqA_Reg, ReqA_Data,
        output ReqB_Valid, ReqB_Reg, ReqB_Data,
        input  ReqA_Ready, ReqB_Ready,
        input  RegWrite, WriteRegister, WriteData, InitDone
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-port register-file write arbiter: clears NUM_REGS entries after reset,
// then grants A/B writebacks with round-robin on contention, 1-cycle write latency.
module reg_write_arbiter #(
    parameter int NUM_REGS = 32
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_prio;            // 0 = A preferred, 1 = B preferred
    logic        r_we, r_done;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    logic        w_ready_a, w_ready_b, w_prio_nxt;
    logic        w_we, w_done;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) r_state <= S_CLEAR;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_cnt == LAST_REG) w_state_nxt = S_RUN;
    end

    always_comb begin
        w_ready_a  = 1'b0;
        w_ready_b  = 1'b0;
        w_prio_nxt = r_prio;
        w_we       = 1'b0;
        w_addr     = r_addr;
        w_data     = r_data;
        w_done     = r_done;
        case (r_state)
            S_CLEAR: begin
                w_we   = 1'b1;
                w_addr = r_cnt;
                w_data = '0;
                w_done = (r_cnt == LAST_REG);
            end
            S_RUN: begin
                w_done    = 1'b1;
                w_ready_a = bus.ReqA_Valid && (!bus.ReqB_Valid || !r_prio);
                w_ready_b = bus.ReqB_Valid && (!bus.ReqA_Valid ||  r_prio);
                // Every contended cycle transfers, so the pointer flips to the loser.
                if (bus.ReqA_Valid && bus.ReqB_Valid) w_prio_nxt = w_ready_a;
                if (w_ready_a && bus.ReqA_Reg != 5'd0) begin
                    w_we   = 1'b1;
                    w_addr = bus.ReqA_Reg;
                    w_data = bus.ReqA_Data;
                end else if (w_ready_b && bus.ReqB_Reg != 5'd0) begin
                    w_we   = 1'b1;
                    w_addr = bus.ReqB_Reg;
                    w_data = bus.ReqB_Data;
                end
            end
            default: ;
        endcase
        if (i_Reset) begin
            w_ready_a = 1'b0;
            w_ready_b = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_cnt  <= '0;
            r_prio <= 1'b0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            if (r_state == S_CLEAR && r_cnt != LAST_REG) r_cnt <= r_cnt + 5'd1;
            r_prio <= w_prio_nxt;
            r_we   <= w_we;
            r_addr <= w_addr;
            r_data <= w_data;
            r_done <= w_done;
        end
    end

    assign bus.ReqA_Ready    = w_ready_a;
    assign bus.ReqB_Ready    = w_ready_b;
    assign bus.RegWrite      = r_we;
    assign bus.WriteRegister = r_addr;
    assign bus.WriteData     = r_data;
    assign bus.InitDone      = r_done;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a
// randomized run scored against a request-queue reference model.
module tb_reg_write_arbiter;
    localparam int NR = 32;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    reg_write_arbiter_if bus();

    reg_write_arbiter #(.NUM_REGS(NR)) dut (
        .i_Clk   (Clk),
        .i_Reset (Reset),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic drop_reqs();
        bus.ReqA_Valid = 1'b0; bus.ReqA_Reg = '0; bus.ReqA_Data = '0;
        bus.ReqB_Valid = 1'b0; bus.ReqB_Reg = '0; bus.ReqB_Data = '0;
    endtask

    // Requests stay valid during reset to show Ready is suppressed.
    task automatic do_reset(input int n);
        @(negedge Clk);
        Reset = 1'b1;
        bus.ReqA_Valid = 1'b1; bus.ReqA_Reg = 5'd4; bus.ReqA_Data = 32'h44;
        bus.ReqB_Valid = 1'b1; bus.ReqB_Reg = 5'd6; bus.ReqB_Data = 32'h66;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clk);
            #1;
            n_checks++;
            if (bus.ReqA_Ready !== 1'b0 || bus.ReqB_Ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_ready: got A=%b B=%b, need 0/0", bus.ReqA_Ready, bus.ReqB_Ready);
            end
            @(posedge Clk); #1;
        end
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0 || bus.InitDone !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: got we=%b reg=%0d data=%h done=%b, need 0/0/0/0",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.InitDone);
        end
        drop_reqs();
    endtask

    // Releases reset and checks the full sweep; request inputs are left as the caller set them.
    task automatic clear_sweep();
        for (int k = 0; k < NR; k++) begin
            @(negedge Clk);
            Reset = 1'b0;
            #1;
            n_checks++;
            if (bus.ReqA_Ready !== 1'b0 || bus.ReqB_Ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clr_ready k=%0d: got A=%b B=%b, need 0/0", k, bus.ReqA_Ready, bus.ReqB_Ready);
            end
            @(posedge Clk); #1;
            n_checks++;
            if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(k) || bus.WriteData !== 32'd0
                || bus.InitDone !== (k == NR - 1)) begin
                n_fail++;
                $display("FAIL clr_write k=%0d: got we=%b reg=%0d data=%h done=%b, need 1/%0d/0/%b",
                         k, bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.InitDone, k, k == NR - 1);
            end
        end
    endtask

    task automatic test_reset();
        drop_reqs();
        do_reset(2);
        clear_sweep();
        @(negedge Clk);
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.InitDone !== 1'b1 || bus.WriteRegister !== 5'(NR - 1)) begin
            n_fail++;
            $display("FAIL idle_after_init: got we=%b done=%b reg=%0d, need 0/1/%0d",
                     bus.RegWrite, bus.InitDone, bus.WriteRegister, NR - 1);
        end
    endtask

    task automatic test_single_a();
        @(negedge Clk);
        bus.ReqA_Valid = 1'b1; bus.ReqA_Reg = 5'd5; bus.ReqA_Data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (bus.ReqA_Ready !== 1'b1 || bus.ReqB_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_a_ready: got A=%b B=%b, need 1/0", bus.ReqA_Ready, bus.ReqB_Ready);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_a_write: got we=%b reg=%0d data=%h, need 1/5/deadbeef",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
        @(negedge Clk);
        drop_reqs();
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF
            || bus.InitDone !== 1'b1) begin
            n_fail++;
            $display("FAIL single_a_hold: got we=%b reg=%0d data=%h done=%b, need 0/5/deadbeef/1",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.InitDone);
        end
    endtask

    task automatic test_reg0();
        @(negedge Clk);
        bus.ReqB_Valid = 1'b1; bus.ReqB_Reg = 5'd0; bus.ReqB_Data = 32'h1234;
        #1;
        n_checks++;
        if (bus.ReqB_Ready !== 1'b1 || bus.ReqA_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_ready: got A=%b B=%b, need 0/1", bus.ReqA_Ready, bus.ReqB_Ready);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_write: got we=%b, need 0", bus.RegWrite);
        end
        @(negedge Clk);
        drop_reqs();
    endtask

    // Pointer is at A here: no contended transfer has happened since reset.
    task automatic test_back_to_back();
        int na = 0;
        int nb = 0;
        for (int i = 0; i < 4; i++) begin
            logic        exp_a;
            logic [4:0]  exp_reg;
            logic [31:0] exp_data;
            @(negedge Clk);
            bus.ReqA_Valid = 1'b1; bus.ReqA_Reg = 5'(1 + 2 * na); bus.ReqA_Data = 32'hA000_0000 + 32'(na);
            bus.ReqB_Valid = 1'b1; bus.ReqB_Reg = 5'(2 + 2 * nb); bus.ReqB_Data = 32'hB000_0000 + 32'(nb);
            exp_a    = (i % 2 == 0);
            exp_reg  = exp_a ? 5'(1 + 2 * na) : 5'(2 + 2 * nb);
            exp_data = exp_a ? 32'hA000_0000 + 32'(na) : 32'hB000_0000 + 32'(nb);
            #1;
            n_checks++;
            if (bus.ReqA_Ready !== exp_a || bus.ReqB_Ready !== !exp_a) begin
                n_fail++;
                $display("FAIL b2b_grant i=%0d: got A=%b B=%b, need %b/%b", i, bus.ReqA_Ready, bus.ReqB_Ready, exp_a, !exp_a);
            end
            @(posedge Clk); #1;
            n_checks++;
            if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== exp_reg || bus.WriteData !== exp_data) begin
                n_fail++;
                $display("FAIL b2b_write i=%0d: got we=%b reg=%0d data=%h, need 1/%0d/%h",
                         i, bus.RegWrite, bus.WriteRegister, bus.WriteData, exp_reg, exp_data);
            end
            if (exp_a) na++; else nb++;
        end
        @(negedge Clk);
        drop_reqs();
    endtask

    task automatic test_reset_mid_clear();
        do_reset(2);
        for (int k = 0; k < 9; k++) begin
            @(negedge Clk);
            Reset = 1'b0;
            @(posedge Clk);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.InitDone !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_clear_reset: got we=%b reg=%0d done=%b, need 0/0/0",
                     bus.RegWrite, bus.WriteRegister, bus.InitDone);
        end
        clear_sweep();
    endtask

    task automatic test_hold_during_clear();
        do_reset(1);
        bus.ReqA_Valid = 1'b1; bus.ReqA_Reg = 5'd7; bus.ReqA_Data = 32'h77;
        bus.ReqB_Valid = 1'b1; bus.ReqB_Reg = 5'd9; bus.ReqB_Data = 32'h99;
        clear_sweep();
        @(negedge Clk); #1;
        n_checks++;
        if (bus.ReqA_Ready !== 1'b1 || bus.ReqB_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_run_grant: got A=%b B=%b, need 1/0", bus.ReqA_Ready, bus.ReqB_Ready);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd7 || bus.WriteData !== 32'h77) begin
            n_fail++;
            $display("FAIL first_run_write: got we=%b reg=%0d data=%h, need 1/7/77",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
        @(negedge Clk);
        bus.ReqA_Valid = 1'b0;
        #1;
        n_checks++;
        if (bus.ReqB_Ready !== 1'b1 || bus.ReqA_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL second_run_grant: got A=%b B=%b, need 0/1", bus.ReqA_Ready, bus.ReqB_Ready);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd9 || bus.WriteData !== 32'h99) begin
            n_fail++;
            $display("FAIL second_run_write: got we=%b reg=%0d data=%h, need 1/9/99",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
        @(negedge Clk);
        drop_reqs();
    endtask

    task automatic test_reset_mid_run();
        @(negedge Clk);
        bus.ReqA_Valid = 1'b1; bus.ReqA_Reg = 5'd3; bus.ReqA_Data = 32'h3333;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (bus.ReqA_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_ready: got A=%b, need 0", bus.ReqA_Ready);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (bus.RegWrite !== 1'b0 || bus.InitDone !== 1'b0 || bus.WriteRegister !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset: got we=%b done=%b reg=%0d, need 0/0/0",
                     bus.RegWrite, bus.InitDone, bus.WriteRegister);
        end
        drop_reqs();
        clear_sweep();
    endtask

    // Model: each side holds at most one pending request; on contention the side
    // that lost the previous contention wins, so grants must alternate.
    task automatic test_random();
        bit          pa = 0, pb = 0;
        logic [4:0]  ra = '0, rb = '0;
        logic [31:0] da = '0, db = '0;
        bit          b_turn = 0;
        int          wait_a = 0, wait_b = 0;
        for (int c = 0; c < 400; c++) begin
            bit          ga, gb, exp_we;
            logic [4:0]  exp_reg;
            logic [31:0] exp_data;
            @(negedge Clk);
            if (!pa && $urandom_range(2) != 0) begin
                pa = 1; ra = 5'($urandom_range(31)); da = $urandom;
            end
            if (!pb && $urandom_range(2) != 0) begin
                pb = 1; rb = 5'($urandom_range(31)); db = $urandom;
            end
            bus.ReqA_Valid = pa; bus.ReqA_Reg = ra; bus.ReqA_Data = da;
            bus.ReqB_Valid = pb; bus.ReqB_Reg = rb; bus.ReqB_Data = db;
            if (pa && pb) begin
                ga = !b_turn; gb = b_turn; b_turn = !b_turn;
            end else begin
                ga = pa; gb = pb;
            end
            exp_we   = (ga && ra != 0) || (gb && rb != 0);
            exp_reg  = ga ? ra : rb;
            exp_data = ga ? da : db;
            #1;
            n_checks++;
            if (bus.ReqA_Ready !== ga || bus.ReqB_Ready !== gb) begin
                n_fail++;
                $display("FAIL rnd_grant c=%0d: got A=%b B=%b, need %b/%b", c, bus.ReqA_Ready, bus.ReqB_Ready, ga, gb);
            end
            wait_a = (pa && !bus.ReqA_Ready) ? wait_a + 1 : 0;
            wait_b = (pb && !bus.ReqB_Ready) ? wait_b + 1 : 0;
            n_checks++;
            if (wait_a > 1 || wait_b > 1) begin
                n_fail++;
                $display("FAIL rnd_starve c=%0d: got waitA=%0d waitB=%0d, need <=1", c, wait_a, wait_b);
            end
            @(posedge Clk); #1;
            n_checks++;
            if (bus.RegWrite !== exp_we || (exp_we && (bus.WriteRegister !== exp_reg || bus.WriteData !== exp_data))) begin
                n_fail++;
                $display("FAIL rnd_write c=%0d: got we=%b reg=%0d data=%h, need %b/%0d/%h",
                         c, bus.RegWrite, bus.WriteRegister, bus.WriteData, exp_we, exp_reg, exp_data);
            end
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        @(negedge Clk);
        drop_reqs();
    endtask

    initial begin
        drop_reqs();
        test_reset();
        test_single_a();
        test_reg0();
        test_back_to_back();
        test_reset_mid_clear();
        test_hold_during_clear();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NUM_REGS, default 32, number of register-file entries cleared at init; legal range 2..32.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ReqA_Valid  in  1  requester A (ALU writeback) has a write pending.
REQ-005 ReqA_Reg  in  5  requester A destination register.
REQ-006 ReqA_Data  in  32  requester A write data.
REQ-007 ReqA_Ready  out  1  requester A write accepted this cycle.
REQ-008 ReqB_Valid  in  1  requester B (load writeback) has a write pending.
REQ-009 ReqB_Reg  in  5  requester B destination register.
REQ-010 ReqB_Data  in  32  requester B write data.
REQ-011 ReqB_Ready  out  1  requester B write accepted this cycle.
REQ-012 RegWrite  out  1  write enable to the register file, registered.
REQ-013 WriteRegister  out  5  register-file write address, registered.
REQ-014 WriteData  out  32  register-file write data, registered.
REQ-015 InitDone  out  1  high once the init clear sweep has completed.

Function
REQ-016 The FSM SHALL have two states: CLEAR and RUN.
REQ-017 CLEAR behaviour:
- a 5-bit counter starts at 0;
- each edge loads RegWrite=1, WriteRegister=counter, WriteData=0, then increments the counter;
- ReqA_Ready=ReqB_Ready=0 throughout.
REQ-018 The edge that loads WriteRegister=NUM_REGS-1 SHALL also set InitDone=1 and move the FSM to RUN.
REQ-019 In RUN, InitDone SHALL stay 1 until Reset.
REQ-020 A transfer on port X SHALL be defined as ReqX_Valid && ReqX_Ready.
REQ-021 Ready grant in RUN, combinational:
- only one requester valid: that requester is granted Ready=1;
- both valid: only the requester selected by the priority pointer is granted;
- neither valid: both Ready=0.
REQ-022 At most one Ready SHALL be high in any cycle.
REQ-023 Priority pointer:
- selects A or B;
- after a transfer while both were valid, points to the requester that lost;
- unchanged otherwise.
REQ-024 Write latency SHALL be 1 cycle: the edge ending a transfer cycle loads RegWrite=1 with the winner's Reg/Data.
REQ-025 A transfer with Reg==0 SHALL be accepted (Ready=1) but SHALL load RegWrite=0, since register 0 is never written in RUN.
REQ-026 A RUN cycle with no transfer SHALL load RegWrite=0; WriteRegister/WriteData SHALL hold their previous values.
REQ-027 A requester SHALL hold Valid/Reg/Data stable until its transfer; the arbiter need not tolerate withdrawal.
REQ-028 Sustained contention SHALL alternate grants A,B,A,B...; neither requester waits more than 1 cycle while the other is valid.
REQ-029 The counter SHALL never exceed NUM_REGS-1 and SHALL not wrap during CLEAR.

Reset
REQ-030 While Reset=1 at an edge, the block SHALL load:
- FSM=CLEAR, counter=0, pointer=A;
- RegWrite=0, WriteRegister=0, WriteData=0, InitDone=0.
REQ-031 ReqA_Ready and ReqB_Ready SHALL be 0 during any cycle with Reset=1.
REQ-032 Reset asserted mid-CLEAR or mid-RUN SHALL abort all activity and restart the full clear sweep from register 0 after release; an accepted write not yet presented is discarded.
REQ-033 The first clear write (register 0) SHALL appear on the first edge with Reset=0.

Verification
REQ-034 Reset 2 cycles then release, no requests:
- edges 1..32 show RegWrite=1, WriteRegister=0..31, WriteData=0;
- InitDone rises on edge 32;
- RegWrite=0 afterwards.
REQ-035 After init, A only, Reg=5, Data=0xDEADBEEF, 1 cycle: ReqA_Ready=1 that cycle; next edge RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF; following edge RegWrite=0.
REQ-036 After init, A and B both valid for 4 transfers (A:Reg1..., B:Reg2...): grants A,B,A,B; register-file writes in that order on consecutive edges; never both Ready.
REQ-037 After init, B Reg=0 Data=0x1234: ReqB_Ready=1; next edge RegWrite=0.
REQ-038 Reset asserted at edge 10 of the clear sweep, released 1 cycle later: sweep restarts at WriteRegister=0; InitDone stays 0 until 32 further edges.
REQ-039 Requests held Valid during CLEAR: Ready=0 until InitDone=1; the first transfer occurs in the first RUN cycle; no write collides with the final clear write.
